// File: rtl/ppu_pkg.sv
// Purpose: shared constants, state encoding and width helper for the PPU scheduler.
// Ports  : none (package).
package ppu_pkg;

    localparam int unsigned ROWS_PER_TILE = 16;
    localparam int unsigned TILES_PER_VEC = 4;
    localparam int unsigned VSQ_DEPTH     = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ppu_state_e;

    // Index width able to address n items; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppu_rr_arb.sv
// Purpose: N-way round-robin arbiter. Searches from ptr_i upward (wrapping) for the
//          first request that is not masked.
// Ports  : req_i      request vector
//          mask_i     requests to ignore this cycle
//          ptr_i      highest-priority index
//          gnt_oh_o   one-hot grant (combinational)
//          gnt_idx_o  grant index (combinational)
//          gnt_vld_o  a grant exists (combinational)
module ppu_rr_arb
    import ppu_pkg::*;
#(
    parameter int unsigned N_BANK = 2
) (
    input  logic [N_BANK-1:0]         req_i,
    input  logic [N_BANK-1:0]         mask_i,
    input  logic [idx_w(N_BANK)-1:0]  ptr_i,
    output logic [N_BANK-1:0]         gnt_oh_o,
    output logic [idx_w(N_BANK)-1:0]  gnt_idx_o,
    output logic                      gnt_vld_o
);

    localparam int unsigned SEL_W = idx_w(N_BANK);

    // Walk candidates in priority order; the first eligible one wins.
    always_comb begin
        int unsigned      k;
        logic [SEL_W-1:0] idx;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        k         = 0;
        idx       = '0;
        for (int unsigned i = 0; i < N_BANK; i++) begin
            k   = (32'(ptr_i) + i) % N_BANK;
            idx = SEL_W'(k);
            if (!gnt_vld_o && req_i[idx] && !mask_i[idx]) begin
                gnt_vld_o     = 1'b1;
                gnt_idx_o     = idx;
                gnt_oh_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppu_sched.sv
// Purpose: sequences the PPU over accumulator tiles: round-robin bank grant, PPU start
//          pulse, 16-row read stepping, bank release, 4 tiles per vector, then a fixed
//          drain hold-off while the quantizer empties the VSQ buffer.
// Ports  : i_clk, i_rst (sync, active-high), i_en (allow new grants), i_flush (abort vector),
//          i_bank_rdy (per-bank tile ready), o_bank_release (1-cycle pulse per bank),
//          o_acc_sel (bank on PPU input), o_acc_row (row index), o_ppu_start (1-cycle pulse),
//          o_tile_cnt (tile in vector), o_busy, o_vec_done (1-cycle pulse), o_vec_cnt.
// Config : PPU_SCHED_PERF_EN adds saturating o_busy_cyc (ARM/RUN cycles) and
//          o_stall_cyc (IDLE cycles inside a started vector), cleared only by i_rst.
module ppu_sched
    import ppu_pkg::*;
#(
    parameter int unsigned N_BANK    = 2,
    parameter int unsigned DRAIN_CYC = 66,
    parameter int unsigned VCNT_W    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_flush,
    input  logic [N_BANK-1:0]         i_bank_rdy,
    output logic [N_BANK-1:0]         o_bank_release,
    output logic [idx_w(N_BANK)-1:0]  o_acc_sel,
    output logic [3:0]                o_acc_row,
    output logic                      o_ppu_start,
    output logic [1:0]                o_tile_cnt,
    output logic                      o_busy,
    output logic                      o_vec_done,
    output logic [VCNT_W-1:0]         o_vec_cnt
`ifdef PPU_SCHED_PERF_EN
    ,
    output logic [31:0]               o_busy_cyc,
    output logic [31:0]               o_stall_cyc
`endif
);

    localparam int unsigned SEL_W   = idx_w(N_BANK);
    localparam int unsigned DCNT_W  = idx_w(DRAIN_CYC);
    localparam logic [3:0]  ROW_LAST  = 4'(ROWS_PER_TILE - 1);
    localparam logic [1:0]  TILE_LAST = 2'(TILES_PER_VEC - 1);

    ppu_state_e          state_q;
    logic [SEL_W-1:0]    acc_sel_q;
    logic [N_BANK-1:0]   g_oh_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [3:0]          acc_row_q;
    logic [1:0]          tile_cnt_q;
    logic [DCNT_W-1:0]   drain_cnt_q;
    logic [N_BANK-1:0]   release_q;
    logic                start_q;
    logic                busy_q;
    logic                vec_done_q;
    logic [VCNT_W-1:0]   vec_cnt_q;

    logic                last_row;
    logic [SEL_W-1:0]    ptr_inc;
    logic [SEL_W-1:0]    arb_ptr;
    logic [N_BANK-1:0]   arb_mask;
    logic [N_BANK-1:0]   gnt_oh;
    logic [SEL_W-1:0]    gnt_idx;
    logic                gnt_vld;

    assign last_row = (acc_row_q == ROW_LAST);
    assign ptr_inc  = SEL_W'((32'(acc_sel_q) + 32'd1) % N_BANK);

    // Back-to-back grant from RUN already sees the advanced pointer. The current bank stays
    // masked during RUN and in the cycle its release becomes visible, so a bank that has
    // not yet dropped rdy cannot be granted twice for the same tile.
    assign arb_ptr  = (state_q == ST_RUN) ? ptr_inc : ptr_q;
    assign arb_mask = (state_q == ST_RUN) ? g_oh_q  : release_q;

    ppu_rr_arb #(
        .N_BANK    (N_BANK)
    ) u_arb (
        .req_i     (i_bank_rdy),
        .mask_i    (arb_mask),
        .ptr_i     (arb_ptr),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Scheduler FSM with registered outputs; flush overrides any same-cycle action.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            acc_sel_q   <= '0;
            g_oh_q      <= '0;
            ptr_q       <= '0;
            acc_row_q   <= '0;
            tile_cnt_q  <= '0;
            drain_cnt_q <= '0;
            release_q   <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            vec_done_q  <= 1'b0;
            vec_cnt_q   <= '0;
        end else begin
            release_q  <= '0;
            start_q    <= 1'b0;
            vec_done_q <= 1'b0;
            if (i_flush) begin
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                tile_cnt_q  <= '0;
                acc_row_q   <= '0;
                drain_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_en && gnt_vld) begin
                            state_q   <= ST_ARM;
                            acc_sel_q <= gnt_idx;
                            g_oh_q    <= gnt_oh;
                            start_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_ARM: begin
                        state_q   <= ST_RUN;
                        acc_row_q <= '0;
                    end
                    ST_RUN: begin
                        if (!last_row) begin
                            acc_row_q <= acc_row_q + 4'd1;
                        end else begin
                            release_q <= g_oh_q;
                            ptr_q     <= ptr_inc;
                            if (tile_cnt_q == TILE_LAST) begin
                                tile_cnt_q  <= '0;
                                drain_cnt_q <= '0;
                                state_q     <= ST_DRAIN;
                            end else begin
                                tile_cnt_q <= tile_cnt_q + 2'd1;
                                if (i_en && gnt_vld) begin
                                    state_q   <= ST_ARM;
                                    acc_sel_q <= gnt_idx;
                                    g_oh_q    <= gnt_oh;
                                    start_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt_q == DCNT_W'(DRAIN_CYC - 1)) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            vec_done_q  <= 1'b1;
                            vec_cnt_q   <= vec_cnt_q + VCNT_W'(1);
                            drain_cnt_q <= '0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_bank_release = release_q;
    assign o_acc_sel      = acc_sel_q;
    assign o_acc_row      = acc_row_q;
    assign o_ppu_start    = start_q;
    assign o_tile_cnt     = tile_cnt_q;
    assign o_busy         = busy_q;
    assign o_vec_done     = vec_done_q;
    assign o_vec_cnt      = vec_cnt_q;

`ifdef PPU_SCHED_PERF_EN
    logic [31:0] busy_cyc_q;
    logic [31:0] stall_cyc_q;

    // Saturating activity counters; flush does not clear them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if ((state_q == ST_ARM || state_q == ST_RUN) && busy_cyc_q != '1) begin
                busy_cyc_q <= busy_cyc_q + 32'd1;
            end
            if (state_q == ST_IDLE && tile_cnt_q != 2'd0 && stall_cyc_q != '1) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
        end
    end

    assign o_busy_cyc  = busy_cyc_q;
    assign o_stall_cyc = stall_cyc_q;
`endif

endmodule
